// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: word, op encoding, status flags, sequencer states.
// Flag storage is selected by ALU_ARB_FLAGS_PER_REQ_EN (see alu_arbiter.sv).
package alu_arbiter_pkg;

  typedef logic [31:0] t_reg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_INC  = 4'd4,
    OP_DEC  = 4'd5,
    OP_COMP = 4'd6,
    OP_AND  = 4'd7,
    OP_OR   = 4'd8,
    OP_XOR  = 4'd9,
    OP_BIT  = 4'd10,
    OP_TEST = 4'd11
  } t_alu_op;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic over;
  } t_flags;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } t_alu_arb_state;

  localparam logic ARB_OWNER_A = 1'b0;
  localparam logic ARB_OWNER_B = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: one add/subtract datapath plus logic ops; carry is a borrow on
// subtracts. COMP/BIT/TEST return reg2 unchanged and only produce flags.
module alu
  import alu_arbiter_pkg::*;
(
  input  t_alu_op op,
  input  t_reg    reg2,
  input  t_reg    reg3,
  input  logic    carry_in,
  output t_reg    result,
  output t_flags  flags
);

  t_reg        rhs_s;
  logic        cin_s;
  logic        sub_s;
  logic        arith_s;
  logic [32:0] wide_s;
  t_reg        value_s;
  t_reg        flag_src_s;

  // Operand conditioning for the shared 33-bit add/subtract
  always_comb begin
    rhs_s   = reg3;
    cin_s   = 1'b0;
    sub_s   = 1'b0;
    arith_s = 1'b1;
    case (op)
      OP_ADD:  cin_s = 1'b0;
      OP_ADDC: cin_s = carry_in;
      OP_SUB:  sub_s = 1'b1;
      OP_SUBC: begin sub_s = 1'b1; cin_s = carry_in; end
      OP_INC:  rhs_s = 32'd1;
      OP_DEC:  begin rhs_s = 32'd1; sub_s = 1'b1; end
      OP_COMP: sub_s = 1'b1;
      default: arith_s = 1'b0;
    endcase
    if (sub_s) begin
      wide_s = {1'b0, reg2} - {1'b0, rhs_s} - {32'd0, cin_s};
    end else begin
      wide_s = {1'b0, reg2} + {1'b0, rhs_s} + {32'd0, cin_s};
    end
  end

  // Result selection and flag derivation
  always_comb begin
    value_s    = wide_s[31:0];
    flag_src_s = wide_s[31:0];
    case (op)
      OP_AND:  begin value_s = reg2 & reg3; flag_src_s = reg2 & reg3; end
      OP_OR:   begin value_s = reg2 | reg3; flag_src_s = reg2 | reg3; end
      OP_XOR:  begin value_s = reg2 ^ reg3; flag_src_s = reg2 ^ reg3; end
      OP_BIT:  begin value_s = reg2; flag_src_s = reg2 & reg3; end
      OP_TEST: begin value_s = reg2; flag_src_s = reg2; end
      OP_COMP: begin value_s = reg2; flag_src_s = wide_s[31:0]; end
      default: begin value_s = wide_s[31:0]; flag_src_s = wide_s[31:0]; end
    endcase
    result     = value_s;
    flags.zero = (flag_src_s == 32'd0);
    flags.neg  = flag_src_s[31];
    if (arith_s) begin
      flags.carry = wide_s[32];
      if (sub_s) begin
        flags.over = (reg2[31] != rhs_s[31]) && (wide_s[31] != reg2[31]);
      end else begin
        flags.over = (reg2[31] == rhs_s[31]) && (wide_s[31] != reg2[31]);
      end
    end else begin
      flags.carry = 1'b0;
      flags.over  = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin valid/ready arbiter sharing one ALU between requesters A and B.
// Define ALU_ARB_FLAGS_PER_REQ_EN for private per-requester flag registers.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid_a,
  input  logic       req_valid_b,
  output logic       req_ready_a,
  output logic       req_ready_b,
  input  t_alu_op    op_a,
  input  t_alu_op    op_b,
  input  t_reg       reg2_a,
  input  t_reg       reg3_a,
  input  t_reg       reg2_b,
  input  t_reg       reg3_b,
  output logic       resp_valid_a,
  output logic       resp_valid_b,
  output t_reg       result,
  output logic [3:0] flags_a,
  output logic [3:0] flags_b
);

  t_alu_arb_state state_r, state_nxt_s;
  logic           last_grant_r, owner_r;
  t_alu_op        op_r;
  t_reg           reg2_r, reg3_r, result_r, alu_result_s;
  t_flags         alu_flags_s;
  logic           grant_a_s, grant_b_s, accept_a_s, accept_b_s, carry_in_s;
  logic           resp_valid_a_r, resp_valid_b_r;

  // Round-robin winner; ready is gated off in EXEC and while reset is held
  always_comb begin
    grant_a_s  = req_valid_a && (!req_valid_b || (last_grant_r == ARB_OWNER_B));
    grant_b_s  = req_valid_b && !grant_a_s;
    accept_a_s = reset && (state_r != EXEC) && grant_a_s;
    accept_b_s = reset && (state_r != EXEC) && grant_b_s;
  end

  assign req_ready_a = accept_a_s;
  assign req_ready_b = accept_b_s;

  // Sequencer next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept_a_s || accept_b_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC:    state_nxt_s = RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and request capture on acceptance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= ARB_OWNER_B;
      owner_r      <= ARB_OWNER_A;
      op_r         <= OP_ADD;
      reg2_r       <= 32'd0;
      reg3_r       <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_a_s) begin
        owner_r      <= ARB_OWNER_A;
        last_grant_r <= ARB_OWNER_A;
        op_r         <= op_a;
        reg2_r       <= reg2_a;
        reg3_r       <= reg3_a;
      end else if (accept_b_s) begin
        owner_r      <= ARB_OWNER_B;
        last_grant_r <= ARB_OWNER_B;
        op_r         <= op_b;
        reg2_r       <= reg2_b;
        reg3_r       <= reg3_b;
      end
    end
  end

  alu u_alu (
    .op       (op_r),
    .reg2     (reg2_r),
    .reg3     (reg3_r),
    .carry_in (carry_in_s),
    .result   (alu_result_s),
    .flags    (alu_flags_s)
  );

  // Result register and one-cycle response pulse following EXEC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_r       <= 32'd0;
      resp_valid_a_r <= 1'b0;
      resp_valid_b_r <= 1'b0;
    end else begin
      resp_valid_a_r <= (state_r == EXEC) && (owner_r == ARB_OWNER_A);
      resp_valid_b_r <= (state_r == EXEC) && (owner_r == ARB_OWNER_B);
      if (state_r == EXEC) begin
        result_r <= alu_result_s;
      end
    end
  end

  assign result       = result_r;
  assign resp_valid_a = resp_valid_a_r;
  assign resp_valid_b = resp_valid_b_r;

`ifdef ALU_ARB_FLAGS_PER_REQ_EN
  t_flags flags_a_r, flags_b_r;

  // Private flag register per requester, written by its own completions
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags_a_r <= 4'b0000;
      flags_b_r <= 4'b0000;
    end else if (state_r == EXEC) begin
      if (owner_r == ARB_OWNER_A) begin
        flags_a_r <= alu_flags_s;
      end else begin
        flags_b_r <= alu_flags_s;
      end
    end
  end

  assign carry_in_s = (owner_r == ARB_OWNER_A) ? flags_a_r.carry : flags_b_r.carry;
  assign flags_a    = flags_a_r;
  assign flags_b    = flags_b_r;
`else
  t_flags flags_r;

  // Single flag register shared by whichever requester completes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags_r <= 4'b0000;
    end else if (state_r == EXEC) begin
      flags_r <= alu_flags_s;
    end
  end

  assign carry_in_s = flags_r.carry;
  assign flags_a    = flags_r;
  assign flags_b    = flags_r;
`endif

endmodule
